// File: rtl/periph_hub.sv
// ============================================================================
// periph_hub
// ----------------------------------------------------------------------------
// Memory-mapped peripheral hub between the core's IO bus and the board
// peripherals (LEDs, seven-segment display, DIP switches, buttons).
//
// It provides NUM_OUT read/write 32-bit output registers and NUM_IN input
// ports. Each input port has a two-flop synchroniser, a debouncer, a sticky
// change flag in STATUS (write-1-to-clear), an enable bit in MASK, and all
// of them feed one level-sensitive interrupt.
//
// Address window: 256 bytes starting at BASE. Only ADDR[31:8] selects the
// window and ADDR[7:2] selects the 32-bit word, so byte lanes alias.
//   0x00 + 4k : output register k            (R/W, k < NUM_OUT)
//   0x40 + 4j : debounced value of port j    (RO, zero-extended, j < NUM_IN)
//   0x80      : STATUS                       (read, write-1-to-clear)
//   0x84      : MASK                         (R/W)
// Anything else in the window, and any address outside it, reads 0 and
// ignores writes.
//
// Ports:
//   CLK    : system clock, all state on the rising edge
//   Reset  : asynchronous, active-high reset
//   ADDR   : byte address from the core
//   WE     : write strobe, sampled on the rising edge of CLK
//   WD     : write data
//   RD     : read data, combinational from ADDR and registered state
//   IN_RAW : raw asynchronous inputs, port j at bits [j*IN_W +: IN_W]
//   OUT    : output registers, register k at bits [k*32 +: 32]
//   IRQ    : level interrupt, high while any unmasked STATUS bit is set
// ============================================================================
module periph_hub #(
    parameter logic [31:0] BASE       = 32'hFFFF_FF00,
    parameter int          NUM_OUT    = 2,
    parameter int          NUM_IN     = 1,
    parameter int          IN_W       = 7,
    parameter int          DEB_CYCLES = 16
) (
    input  logic                   CLK,
    input  logic                   Reset,
    input  logic [31:0]            ADDR,
    input  logic                   WE,
    input  logic [31:0]            WD,
    output logic [31:0]            RD,
    input  logic [NUM_IN*IN_W-1:0] IN_RAW,
    output logic [NUM_OUT*32-1:0]  OUT,
    output logic                   IRQ
);

    // Counter wide enough to hold DEB_CYCLES-1 for any legal DEB_CYCLES.
    localparam int CNT_W = $clog2(DEB_CYCLES + 1);

    // Word indices (ADDR[7:2]) of the register groups inside the window.
    localparam logic [5:0] IN_BASE_WORD = 6'd16;
    localparam logic [5:0] STATUS_WORD  = 6'd32;
    localparam logic [5:0] MASK_WORD    = 6'd33;

    // ------------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------------
    logic       hit;
    logic [5:0] word;
    logic       wr_en;

    assign hit   = (ADDR[31:8] == BASE[31:8]);
    assign word  = ADDR[7:2];
    assign wr_en = WE & hit;

    // The byte-lane bits select nothing: any byte address in a word hits
    // that word.
    logic unused_addr_bits;
    assign unused_addr_bits = ^ADDR[1:0];

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [NUM_OUT-1:0][31:0]    out_reg;
    logic [NUM_IN*IN_W-1:0]      s1;
    logic [NUM_IN*IN_W-1:0]      s2;
    logic [NUM_IN-1:0][IN_W-1:0] stable;
    logic [NUM_IN-1:0][CNT_W-1:0] cnt;
    logic [NUM_IN-1:0]           status;
    logic [NUM_IN-1:0]           mask;

    // Per-port "accept this edge" pulse and the W1C clear vector.
    logic [NUM_IN-1:0]           set_vec;
    logic [NUM_IN-1:0]           clr_vec;

    // ------------------------------------------------------------------------
    // Output registers
    // ------------------------------------------------------------------------
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            out_reg <= '0;
        end else if (wr_en) begin
            for (int k = 0; k < NUM_OUT; k++) begin
                if (word == 6'(k)) begin
                    out_reg[k] <= WD;
                end
            end
        end
    end

    assign OUT = out_reg;

    // ------------------------------------------------------------------------
    // Acceptance: a port's synchronised value has differed from its accepted
    // value for DEB_CYCLES consecutive edges, counting this one. The count is
    // against STABLE, not the previous sample, so a port that wanders between
    // several non-STABLE values keeps counting and lands on whatever it holds
    // at the final edge.
    // ------------------------------------------------------------------------
    always_comb begin
        set_vec = '0;
        for (int j = 0; j < NUM_IN; j++) begin
            set_vec[j] = (s2[j*IN_W +: IN_W] != stable[j]) &&
                         (cnt[j] == CNT_W'(DEB_CYCLES - 1));
        end
    end

    // ------------------------------------------------------------------------
    // Synchroniser and debouncer. Any sample equal to STABLE restarts the
    // count, so only an uninterrupted run of differing samples is accepted.
    // ------------------------------------------------------------------------
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            s1     <= '0;
            s2     <= '0;
            stable <= '0;
            cnt    <= '0;
        end else begin
            s1 <= IN_RAW;
            s2 <= s1;
            for (int j = 0; j < NUM_IN; j++) begin
                if (s2[j*IN_W +: IN_W] == stable[j]) begin
                    cnt[j] <= '0;
                end else if (set_vec[j]) begin
                    stable[j] <= s2[j*IN_W +: IN_W];
                    cnt[j]    <= '0;
                end else begin
                    cnt[j] <= cnt[j] + CNT_W'(1);
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // STATUS and MASK. A change accepted on the same edge as a W1C write of
    // the same bit wins, so software never loses an event it has not seen.
    // ------------------------------------------------------------------------
    assign clr_vec = (wr_en && (word == STATUS_WORD)) ? WD[NUM_IN-1:0] : '0;

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            status <= '0;
            mask   <= '0;
        end else begin
            status <= (status & ~clr_vec) | set_vec;
            if (wr_en && (word == MASK_WORD)) begin
                mask <= WD[NUM_IN-1:0];
            end
        end
    end

    // Both operands are flops, so IRQ cannot glitch on bus activity.
    assign IRQ = |(status & mask);

    // ------------------------------------------------------------------------
    // Read mux. Defaults to zero for misses, holes and out-of-range indices.
    // ------------------------------------------------------------------------
    always_comb begin
        RD = '0;
        if (hit) begin
            for (int k = 0; k < NUM_OUT; k++) begin
                if (word == 6'(k)) begin
                    RD = out_reg[k];
                end
            end
            for (int j = 0; j < NUM_IN; j++) begin
                if (word == (IN_BASE_WORD + 6'(j))) begin
                    RD = 32'(stable[j]);
                end
            end
            if (word == STATUS_WORD) begin
                RD = 32'(status);
            end
            if (word == MASK_WORD) begin
                RD = 32'(mask);
            end
        end
    end

endmodule

// File: tb/tb_periph_hub.sv
// ============================================================================
// tb_periph_hub
// ----------------------------------------------------------------------------
// Self-checking bench for periph_hub with DEB_CYCLES=4, NUM_OUT=2, NUM_IN=1,
// IN_W=7. A table of bus vectors covers the register map, hand-written
// sequences cover debounce timing, W1C/IRQ, set-vs-clear and async reset,
// and a randomized run is checked against a reference model that works from
// input history rather than counters.
// ============================================================================
module tb_periph_hub;

   localparam logic [31:0] BASE       = 32'hFFFF_FF00;
   localparam logic [23:0] BASE_HI    = 24'hFF_FFFF;
   localparam int          NUM_OUT    = 2;
   localparam int          NUM_IN     = 1;
   localparam int          IN_W       = 7;
   localparam int          DEB_CYCLES = 4;
   localparam int          IW         = NUM_IN * IN_W;
   localparam int          OW         = NUM_OUT * 32;

   localparam logic [31:0] OUT0_A   = 32'hFFFF_FF00;
   localparam logic [31:0] IN0_A    = 32'hFFFF_FF40;
   localparam logic [31:0] STATUS_A = 32'hFFFF_FF80;
   localparam logic [31:0] MASK_A   = 32'hFFFF_FF84;

   logic          CLK;
   logic          Reset;
   logic [31:0]   ADDR;
   logic          WE;
   logic [31:0]   WD;
   logic [31:0]   RD;
   logic [IW-1:0] IN_RAW;
   logic [OW-1:0] OUT;
   logic          IRQ;

   int compareCount = 0;
   int failCount    = 0;

   periph_hub #(
      .BASE       (BASE),
      .NUM_OUT    (NUM_OUT),
      .NUM_IN     (NUM_IN),
      .IN_W       (IN_W),
      .DEB_CYCLES (DEB_CYCLES)
   ) dut (
      .CLK    (CLK),
      .Reset  (Reset),
      .ADDR   (ADDR),
      .WE     (WE),
      .WD     (WD),
      .RD     (RD),
      .IN_RAW (IN_RAW),
      .OUT    (OUT),
      .IRQ    (IRQ)
   );

   // 10 ns clock; rising edges at 5, 15, 25, ...
   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // -------------------------------------------------------------------------
   // Reference model. The debouncer is described by its rule: the value the
   // synchroniser presents at an edge is the raw input sampled two edges
   // earlier, and a port accepts that value once the last DEB_CYCLES
   // presented samples all differ from the currently accepted value.
   // -------------------------------------------------------------------------
   logic [31:0]     mOut    [NUM_OUT];
   logic [IN_W-1:0] mStable [NUM_IN];
   logic [NUM_IN-1:0] mStatus;
   logic [NUM_IN-1:0] mMask;
   logic [IW-1:0]   rawQ  [$];
   logic [IW-1:0]   seenQ [$];

   always @(posedge CLK or posedge Reset) begin : refModel
      logic [IW-1:0]     seen;
      logic [NUM_IN-1:0] setV;
      logic [NUM_IN-1:0] clrV;
      logic [IN_W-1:0]   newVal [NUM_IN];
      bit                allDiff;
      int                w;
      if (Reset) begin
         for (int k = 0; k < NUM_OUT; k++) mOut[k] = '0;
         for (int j = 0; j < NUM_IN; j++) mStable[j] = '0;
         mStatus = '0;
         mMask   = '0;
         rawQ.delete();
         rawQ.push_back('0);
         rawQ.push_back('0);
         seenQ.delete();
      end else begin
         rawQ.push_back(IN_RAW);
         if (rawQ.size() > 4) void'(rawQ.pop_front());
         seen = rawQ[rawQ.size() - 3];
         seenQ.push_back(seen);
         if (seenQ.size() > DEB_CYCLES) void'(seenQ.pop_front());
         setV = '0;
         for (int j = 0; j < NUM_IN; j++) begin
            newVal[j] = mStable[j];
            if (seenQ.size() == DEB_CYCLES) begin
               allDiff = 1'b1;
               for (int i = 0; i < DEB_CYCLES; i++) begin
                  if (seenQ[i][j*IN_W +: IN_W] == mStable[j]) allDiff = 1'b0;
               end
               if (allDiff) begin
                  setV[j]   = 1'b1;
                  newVal[j] = seen[j*IN_W +: IN_W];
               end
            end
         end
         clrV = '0;
         if (WE && (ADDR[31:8] == BASE_HI)) begin
            w = int'(ADDR[7:2]);
            if (w < NUM_OUT) mOut[w] = WD;
            if (w == 33) mMask = WD[NUM_IN-1:0];
            if (w == 32) clrV = WD[NUM_IN-1:0];
         end
         mStatus = (mStatus & ~clrV) | setV;
         for (int j = 0; j < NUM_IN; j++) mStable[j] = newVal[j];
      end
   end

   function automatic logic [31:0] modelRead(input logic [31:0] a);
      int w;
      if (a[31:8] != BASE_HI) return 32'h0;
      w = int'(a[7:2]);
      if (w < NUM_OUT) return mOut[w];
      if (w >= 16 && w < 16 + NUM_IN) return 32'(mStable[w-16]);
      if (w == 32) return 32'(mStatus);
      if (w == 33) return 32'(mMask);
      return 32'h0;
   endfunction

   function automatic logic [OW-1:0] modelOut();
      logic [OW-1:0] v;
      for (int k = 0; k < NUM_OUT; k++) v[k*32 +: 32] = mOut[k];
      return v;
   endfunction

   // Random address: mostly interesting words in the window, with random
   // byte-lane bits, sometimes pushed just outside the window.
   function automatic logic [31:0] pickAddr();
      logic [7:0]  offs [10] = '{8'h00, 8'h04, 8'h08, 8'h3C, 8'h40,
                                 8'h44, 8'h80, 8'h84, 8'h88, 8'hFC};
      logic [31:0] a;
      a = {BASE_HI, offs[$urandom_range(0, 9)]} | 32'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) a = a ^ 32'h0000_0100;
      return a;
   endfunction

   // -------------------------------------------------------------------------
   // Bus helpers. Writes are launched mid-cycle and return on the next
   // falling edge, so outputs are always sampled away from the rising edge.
   // -------------------------------------------------------------------------
   task automatic busWrite(input logic [31:0] a, input logic [31:0] d, input logic we);
      ADDR = a;
      WD   = d;
      WE   = we;
      @(posedge CLK);
      @(negedge CLK);
      WE = 1'b0;
   endtask

   task automatic busRead(input logic [31:0] a, output logic [31:0] d);
      ADDR = a;
      #1;
      d = RD;
   endtask

   task automatic checkOutput(input string name, input logic [63:0] actual,
                              input logic [63:0] expected);
      compareCount++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
      end
   endtask

   // -------------------------------------------------------------------------
   // Table-driven register-map vectors
   // -------------------------------------------------------------------------
   typedef struct {
      string       name;
      logic [31:0] addr;
      logic        we;
      logic [31:0] wd;
      logic [31:0] raddr;
      logic [31:0] expRd;
      logic [63:0] expOut;
   } vec_t;

   vec_t vecs [15];

   task automatic setVec(input int i, input string n, input logic [31:0] a,
                         input logic we, input logic [31:0] d, input logic [31:0] ra,
                         input logic [31:0] er, input logic [63:0] eo);
      vecs[i].name   = n;
      vecs[i].addr   = a;
      vecs[i].we     = we;
      vecs[i].wd     = d;
      vecs[i].raddr  = ra;
      vecs[i].expRd  = er;
      vecs[i].expOut = eo;
   endtask

   task automatic applyStimulus(input vec_t v);
      logic [31:0] rd;
      busWrite(v.addr, v.wd, v.we);
      busRead(v.raddr, rd);
      checkOutput({v.name, "_rd"}, 64'(rd), 64'(v.expRd));
      checkOutput({v.name, "_out"}, 64'(OUT), v.expOut);
      checkOutput({v.name, "_irq"}, 64'(IRQ), 64'h0);
   endtask

   // -------------------------------------------------------------------------
   // Main sequence
   // -------------------------------------------------------------------------
   initial begin : mainSeq
      logic [31:0] rd;

      setVec(0,  "wr_out0",   32'hFFFF_FF00, 1'b1, 32'h0000_ABCD, 32'hFFFF_FF00, 32'h0000_ABCD, 64'h0000_0000_0000_ABCD);
      setVec(1,  "wr_out1",   32'hFFFF_FF04, 1'b1, 32'h1234_5678, 32'hFFFF_FF04, 32'h1234_5678, 64'h1234_5678_0000_ABCD);
      setVec(2,  "rd_out0",   32'hFFFF_FF00, 1'b0, 32'h0,         32'hFFFF_FF00, 32'h0000_ABCD, 64'h1234_5678_0000_ABCD);
      setVec(3,  "wr_k15",    32'hFFFF_FF3C, 1'b1, 32'hDEAD_BEEF, 32'hFFFF_FF3C, 32'h0,         64'h1234_5678_0000_ABCD);
      setVec(4,  "wr_k2",     32'hFFFF_FF08, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FF08, 32'h0,         64'h1234_5678_0000_ABCD);
      setVec(5,  "wr_ro_in",  32'hFFFF_FF40, 1'b1, 32'h0000_007F, 32'hFFFF_FF40, 32'h0,         64'h1234_5678_0000_ABCD);
      setVec(6,  "nonhit_wr", 32'h0000_0000, 1'b1, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0,         64'h1234_5678_0000_ABCD);
      setVec(7,  "alias_wr",  32'hFFFF_FF03, 1'b1, 32'hCAFE_F00D, 32'hFFFF_FF00, 32'hCAFE_F00D, 64'h1234_5678_CAFE_F00D);
      setVec(8,  "alias_rd",  32'hFFFF_FF00, 1'b0, 32'h0,         32'hFFFF_FF02, 32'hCAFE_F00D, 64'h1234_5678_CAFE_F00D);
      setVec(9,  "mask_hi",   32'hFFFF_FF84, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FF84, 32'h1,         64'h1234_5678_CAFE_F00D);
      setVec(10, "mask_clr",  32'hFFFF_FF84, 1'b1, 32'hFFFF_FFFE, 32'hFFFF_FF84, 32'h0,         64'h1234_5678_CAFE_F00D);
      setVec(11, "unmapped",  32'hFFFF_FF88, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FF88, 32'h0,         64'h1234_5678_CAFE_F00D);
      setVec(12, "in_j1",     32'hFFFF_FF44, 1'b1, 32'h0000_0055, 32'hFFFF_FF44, 32'h0,         64'h1234_5678_CAFE_F00D);
      setVec(13, "near_base", 32'hFFFF_FE00, 1'b1, 32'h1111_1111, 32'hFFFF_FE00, 32'h0,         64'h1234_5678_CAFE_F00D);
      setVec(14, "stat_read", 32'hFFFF_FF80, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FF80, 32'h0,         64'h1234_5678_CAFE_F00D);

      // Reset values must appear as soon as reset is asserted.
      Reset  = 1'b1;
      IN_RAW = '0;
      ADDR   = '0;
      WE     = 1'b0;
      WD     = '0;
      #1;
      checkOutput("reset_out", 64'(OUT), 64'h0);
      checkOutput("reset_irq", 64'(IRQ), 64'h0);
      busRead(STATUS_A, rd);
      checkOutput("reset_status", 64'(rd), 64'h0);
      busRead(MASK_A, rd);
      checkOutput("reset_mask", 64'(rd), 64'h0);
      @(negedge CLK);
      @(negedge CLK);
      Reset = 1'b0;

      // Register map walk.
      for (int i = 0; i < 15; i++) applyStimulus(vecs[i]);

      // Debounce latency: the new value appears exactly 2+DEB_CYCLES edges
      // after the raw change, not one edge earlier.
      @(negedge CLK);
      IN_RAW = 7'h55;
      for (int e = 1; e <= 2 + DEB_CYCLES; e++) begin
         @(negedge CLK);
         if (e == 1 + DEB_CYCLES) begin
            busRead(IN0_A, rd);
            checkOutput("deb_val_early", 64'(rd), 64'h0);
            busRead(STATUS_A, rd);
            checkOutput("deb_stat_early", 64'(rd), 64'h0);
         end
         if (e == 2 + DEB_CYCLES) begin
            busRead(IN0_A, rd);
            checkOutput("deb_val", 64'(rd), 64'h55);
            busRead(STATUS_A, rd);
            checkOutput("deb_stat", 64'(rd), 64'h1);
         end
      end

      // W1C and IRQ with STATUS=1.
      checkOutput("irq_masked", 64'(IRQ), 64'h0);
      busWrite(STATUS_A, 32'h0, 1'b1);
      busRead(STATUS_A, rd);
      checkOutput("w1c_zero", 64'(rd), 64'h1);
      busWrite(MASK_A, 32'h1, 1'b1);
      checkOutput("irq_unmasked", 64'(IRQ), 64'h1);
      busWrite(STATUS_A, 32'h1, 1'b1);
      busRead(STATUS_A, rd);
      checkOutput("w1c_one", 64'(rd), 64'h0);
      checkOutput("irq_cleared", 64'(IRQ), 64'h0);

      // A 3-cycle glitch is shorter than DEB_CYCLES and must be dropped.
      @(negedge CLK);
      IN_RAW = 7'h7F;
      repeat (3) @(negedge CLK);
      IN_RAW = 7'h55;
      repeat (10) @(negedge CLK);
      busRead(IN0_A, rd);
      checkOutput("pulse_val", 64'(rd), 64'h55);
      busRead(STATUS_A, rd);
      checkOutput("pulse_stat", 64'(rd), 64'h0);

      // W1C on the very edge a new value is accepted: the set must win.
      @(negedge CLK);
      IN_RAW = 7'h2A;
      repeat (1 + DEB_CYCLES) @(negedge CLK);
      ADDR = STATUS_A;
      WD   = 32'h1;
      WE   = 1'b1;
      @(negedge CLK);
      WE = 1'b0;
      busRead(STATUS_A, rd);
      checkOutput("set_wins", 64'(rd), 64'h1);
      busRead(IN0_A, rd);
      checkOutput("set_wins_val", 64'(rd), 64'h2A);

      // Async reset mid-count with OUT and IRQ active.
      busWrite(OUT0_A, 32'hA5A5_0001, 1'b1);
      checkOutput("pre_reset_irq", 64'(IRQ), 64'h1);
      IN_RAW = 7'h11;
      repeat (3) @(negedge CLK);
      #2;
      Reset = 1'b1;
      #1;
      checkOutput("areset_out", 64'(OUT), 64'h0);
      checkOutput("areset_irq", 64'(IRQ), 64'h0);
      busRead(STATUS_A, rd);
      checkOutput("areset_status", 64'(rd), 64'h0);
      busRead(MASK_A, rd);
      checkOutput("areset_mask", 64'(rd), 64'h0);
      busRead(IN0_A, rd);
      checkOutput("areset_val", 64'(rd), 64'h0);
      @(negedge CLK);
      @(negedge CLK);
      Reset = 1'b0;
      for (int e = 1; e <= 2 + DEB_CYCLES; e++) begin
         @(negedge CLK);
         if (e == 1 + DEB_CYCLES) begin
            busRead(STATUS_A, rd);
            checkOutput("post_reset_stat_early", 64'(rd), 64'h0);
         end
         if (e == 2 + DEB_CYCLES) begin
            busRead(STATUS_A, rd);
            checkOutput("post_reset_stat", 64'(rd), 64'h1);
            busRead(IN0_A, rd);
            checkOutput("post_reset_val", 64'(rd), 64'h11);
         end
      end

      // Randomized traffic against the reference model. Input changes are
      // rare enough that many values survive debouncing and some do not.
      for (int c = 0; c < 400; c++) begin
         logic [31:0] a;
         if ($urandom_range(0, 7) == 0) IN_RAW = IW'($urandom);
         busWrite(pickAddr(), $urandom, ($urandom_range(0, 2) == 0));
         a = pickAddr();
         busRead(a, rd);
         checkOutput("rand_rd", 64'(rd), 64'(modelRead(a)));
         checkOutput("rand_out", 64'(OUT), 64'(modelOut()));
         checkOutput("rand_irq", 64'(IRQ), 64'(|(mStatus & mMask)));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
      $finish;
   end

endmodule

// File: doc/periph_hub.md
Name: periph_hub

Overview:
- Parametrised memory-mapped peripheral hub; successor to the fixed LED/SEG/DIP connector.
- Decodes the core's IO bus into NUM_OUT 32-bit output registers and NUM_IN input ports.
- Each input port is synchronised and debounced, with sticky change flags (write-1-to-clear), a mask register and a level interrupt.
- Sits between ARMcore's IO port and the board peripherals (LED, seven-segment, DIP, future switches/buttons).

Parameters:
- BASE, 32'hFFFF_FF00, base of the 256-byte IO window; only ADDR[31:8] is compared.
- NUM_OUT, 2, number of output registers (1..16).
- NUM_IN, 1, number of input ports (1..16).
- IN_W, 7, width of each input port (1..32).
- DEB_CYCLES, 16, consecutive stable cycles required to accept an input change (>=1).

Ports:
- CLK  input  1  system clock, all state on rising edge
- Reset  input  1  asynchronous, active-high reset
- ADDR  input  32  byte address from core
- WE  input  1  write strobe, sampled on CLK rising edge
- WD  input  32  write data
- RD  output  32  read data, combinational from ADDR and registered state
- IN_RAW  input  NUM_IN*IN_W  asynchronous raw inputs; port j occupies bits [j*IN_W +: IN_W]
- OUT  output  NUM_OUT*32  output registers; register k occupies bits [k*32 +: 32]
- IRQ  output  1  level interrupt = |(STATUS & MASK)

Behaviour:
- Hit: ADDR[31:8]==BASE[31:8]. Offset = ADDR[7:2] (word index). ADDR[1:0] is ignored.
- Address map (byte offsets):
  - 0x00+4k: OUT reg k, R/W.
  - 0x40+4j: debounced value of input port j, RO, zero-extended.
  - 0x80: STATUS, bit j set on a debounced change of port j; write-1-to-clear.
  - 0x84: MASK, R/W, low NUM_IN bits.
- Bits at or above NUM_IN in STATUS/MASK read 0 and ignore writes.
- Unmapped offsets, and offsets for k>=NUM_OUT or j>=NUM_IN: read 0, writes ignored. Non-hit reads return 0.
- Writes to RO registers are ignored. Writes take effect at the CLK edge with WE=1 and are visible on RD and OUT in the following cycle.
- Synchroniser: two flops per input bit (s1 -> s2).
- Debounce, per port:
  - Holds STABLE[IN_W] and CNT (clog2(DEB_CYCLES+1) bits).
  - If s2==STABLE: CNT<=0.
  - Else if CNT==DEB_CYCLES-1: STABLE<=s2, CNT<=0, STATUS[j]<=1.
  - Else: CNT<=CNT+1.
  - Any return to the STABLE value restarts the count, so bounces shorter than DEB_CYCLES never propagate.
  - Latency from IN_RAW change to RD/STATUS update is exactly 2+DEB_CYCLES edges.
  - A multi-bit change is accepted as one event. A port that changes to a different non-STABLE value mid-count keeps counting, because the comparison is against STABLE.
- STATUS update per bit:
  - Next = (old & ~(W1C mask)) | set.
  - A set and a W1C on the same edge: set wins, bit stays 1.
- IRQ is combinational from the STATUS and MASK flops, with no extra latency. Glitch-free because both are registered.
- Reset (async assert, value applies immediately): OUT=0, s1/s2=0, STABLE=0, CNT=0, STATUS=0, MASK=0, IRQ=0.
  - Inputs that are high out of reset are reported as a change after 2+DEB_CYCLES cycles. This is intended, so software sees initial switch state.
- Reset mid-debounce discards the count; no STATUS set.

Test Plan:
- Write/readback: DEB_CYCLES=4. Write 0x0000_ABCD to BASE+0x00 and 0x1234_5678 to BASE+0x04 -> next cycle OUT[31:0]=0x0000ABCD, OUT[63:32]=0x12345678; RD at both addresses matches. Write to BASE+0x3C (k=15 > NUM_OUT) -> no change; read of BASE+0x3C returns 0.
- Debounce latency: IN_RAW 0x00 -> 0x55 held. Required: RD@BASE+0x40 = 0x55 and STATUS=1 exactly 6 edges after the change. A 3-cycle pulse of 0x7F -> value and STATUS unchanged.
- W1C and IRQ: STATUS=1, MASK=0 -> IRQ=0. Write MASK=1 -> IRQ=1 next cycle. Write 1 to BASE+0x80 -> STATUS=0, IRQ=0. Write 0 to BASE+0x80 -> no effect.
- Simultaneous set/clear: arrange debounce acceptance on the same edge as a W1C write of bit 0 -> STATUS[0]=1 after that edge.
- Non-hit/address aliasing: ADDR=0x0000_0000 with WE=1 -> OUT unchanged, RD=0. ADDR=BASE+0x03 addresses the same register as BASE+0x00.
- Async reset: assert Reset between clock edges during a debounce count with OUT nonzero -> OUT, STATUS, MASK and IRQ go to 0 immediately. After release with input held, STATUS sets 2+DEB_CYCLES edges later.
